// File: rtl/apb_uart_fifo.sv
// APB3 UART with TX/RX FIFOs, a programmable baud divisor, sticky error flags and a level irq.
// The FIFO buffer helper and the UART top both live in this file.

module apb_uart_fifo_buf #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata_c,
  output logic [$clog2(DEPTH):0]     count_c,
  output logic                       full_c,
  output logic                       empty_c
);
  localparam int unsigned PTR_W = $clog2(DEPTH) + 1;
  localparam int unsigned IDX_W = PTR_W - 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             pop_ok_c, push_ok_c;

  assign count_c = wr_ptr_q - rd_ptr_q;
  assign full_c  = (count_c == PTR_W'(DEPTH));
  assign empty_c = (count_c == '0);
  assign rdata_c = mem_q[rd_ptr_q[IDX_W-1:0]];

  // A pop frees the slot a simultaneous push needs, so push-when-full still lands.
  always_comb begin
    pop_ok_c  = pop & ~empty_c;
    push_ok_c = push & (~full_c | pop_ok_c);
    wr_ptr_d  = wr_ptr_q + PTR_W'(push_ok_c);
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop_ok_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_c) mem_q[wr_ptr_q[IDX_W-1:0]] <= wdata;
  end
endmodule

module apb_uart_fifo #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned DIV_RESET  = 651
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [3:0]  PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  input  logic        PSEL,
  input  logic        PENABLE,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        tx,
  input  logic        rx,
  output logic        irq
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BIT_W = $clog2(DATA_BITS);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic [1:0] reg_sel_c;
  logic       access_c, wr_c, rd_c, ctrl_wr_c, w1c_c;

  assign reg_sel_c = PADDR[3:2];
  assign access_c  = PSEL & PENABLE;
  assign wr_c      = access_c & PWRITE;
  assign rd_c      = access_c & ~PWRITE;
  assign ctrl_wr_c = wr_c & (reg_sel_c == 2'd3);
  assign w1c_c     = wr_c & (reg_sel_c == 2'd0);
  assign PREADY    = access_c;
  assign PSLVERR   = 1'b0;

  logic unused_c;
  assign unused_c = ^{PADDR[1:0], PWDATA[31:18]};

  // Register state
  logic [15:0]          div_q, div_d, tick_cnt_q, tick_cnt_d, div_eff_c;
  logic                 rx_irq_en_q, rx_irq_en_d, tx_irq_en_q, tx_irq_en_d;
  logic                 overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic                 irq_q, irq_d, tick_c;
  state_e               tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic [BIT_W-1:0]     tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [3:0]           tx_tcnt_q, tx_tcnt_d, rx_tcnt_q, rx_tcnt_d;
  logic                 tx_q, tx_d;
  logic [1:0]           sync_q, sync_d;
  logic                 rx_s_c, tx_busy_c;

  // FIFO interfaces
  logic                 tx_push_c, tx_pop_c, tx_full_c, tx_empty_c;
  logic                 rx_push_c, rx_pop_c, rx_full_c, rx_empty_c;
  logic                 fe_set_c, ov_set_c;
  logic [DATA_BITS-1:0] tx_rdata_c, rx_rdata_c;
  logic [CNT_W-1:0]     tx_count_c, rx_count_c;

  assign tx_push_c = wr_c & (reg_sel_c == 2'd1);
  assign rx_pop_c  = rd_c & (reg_sel_c == 2'd2) & ~rx_empty_c;
  assign rx_s_c    = sync_q[1];
  assign tx_busy_c = (tx_state_q != S_IDLE);
  assign tx        = tx_q;
  assign irq       = irq_q;

  apb_uart_fifo_buf #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_tx_fifo (
    .clk(PCLK), .rst(PRESET), .push(tx_push_c), .pop(tx_pop_c),
    .wdata(PWDATA[DATA_BITS-1:0]), .rdata_c(tx_rdata_c), .count_c(tx_count_c),
    .full_c(tx_full_c), .empty_c(tx_empty_c)
  );

  apb_uart_fifo_buf #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_rx_fifo (
    .clk(PCLK), .rst(PRESET), .push(rx_push_c), .pop(rx_pop_c),
    .wdata(rx_shift_q), .rdata_c(rx_rdata_c), .count_c(rx_count_c),
    .full_c(rx_full_c), .empty_c(rx_empty_c)
  );

  // Register map read mux, live only during the access phase
  always_comb begin
    PRDATA = 32'd0;
    if (access_c) begin
      case (reg_sel_c)
        2'd0: PRDATA = {17'd0, 4'(rx_count_c), 4'(tx_count_c), tx_busy_c, frame_err_q,
                        overrun_q, rx_full_c, rx_empty_c, tx_full_c, tx_empty_c};
        2'd2: PRDATA = rx_empty_c ? 32'd0 : 32'(rx_rdata_c);
        2'd3: PRDATA = {14'd0, tx_irq_en_q, rx_irq_en_q, div_q};
        default: PRDATA = 32'd0;
      endcase
    end
  end

  // Control registers, tick generator, sticky flags and irq
  always_comb begin
    div_d       = div_q;
    rx_irq_en_d = rx_irq_en_q;
    tx_irq_en_d = tx_irq_en_q;
    if (ctrl_wr_c) begin
      div_d       = PWDATA[15:0];
      rx_irq_en_d = PWDATA[16];
      tx_irq_en_d = PWDATA[17];
    end
    div_eff_c   = (div_q == 16'd0) ? 16'd1 : div_q;
    tick_c      = (tick_cnt_q >= div_eff_c - 16'd1);
    tick_cnt_d  = (ctrl_wr_c || tick_c) ? 16'd0 : tick_cnt_q + 16'd1;
    ov_set_c    = rx_push_c & rx_full_c & ~rx_pop_c;
    overrun_d   = ov_set_c | (overrun_q & ~(w1c_c & PWDATA[4]));
    frame_err_d = fe_set_c | (frame_err_q & ~(w1c_c & PWDATA[5]));
    irq_d       = (rx_irq_en_q & ~rx_empty_c) | (tx_irq_en_q & tx_empty_c & ~tx_busy_c)
                | overrun_q | frame_err_q;
  end

  // TX framer
  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_tcnt_d  = tx_tcnt_q;
    tx_d       = tx_q;
    tx_pop_c   = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!tx_empty_c) begin
          tx_pop_c   = 1'b1;
          tx_shift_d = tx_rdata_c;
          tx_bit_d   = '0;
          tx_tcnt_d  = 4'd0;
          tx_d       = 1'b0;
          tx_state_d = S_START;
        end
      end
      S_START: if (tick_c) begin
        tx_tcnt_d = tx_tcnt_q + 4'd1;
        if (tx_tcnt_q == 4'd15) begin
          tx_d       = tx_shift_q[0];
          tx_state_d = S_DATA;
        end
      end
      S_DATA: if (tick_c) begin
        tx_tcnt_d = tx_tcnt_q + 4'd1;
        if (tx_tcnt_q == 4'd15) begin
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == BIT_W'(DATA_BITS - 1)) begin
            tx_d       = 1'b1;
            tx_state_d = S_STOP;
          end else begin
            tx_bit_d = tx_bit_q + BIT_W'(1);
            tx_d     = tx_shift_q[1];
          end
        end
      end
      S_STOP: if (tick_c) begin
        tx_tcnt_d = tx_tcnt_q + 4'd1;
        if (tx_tcnt_q == 4'd15) tx_state_d = S_IDLE;
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  // RX deframer: half-bit start qualification, then centre sampling
  always_comb begin
    sync_d     = {sync_q[0], rx};
    rx_state_d = rx_state_q;
    rx_shift_d = rx_shift_q;
    rx_bit_d   = rx_bit_q;
    rx_tcnt_d  = rx_tcnt_q;
    rx_push_c  = 1'b0;
    fe_set_c   = 1'b0;
    case (rx_state_q)
      S_IDLE: if (!rx_s_c) begin
        rx_tcnt_d  = 4'd0;
        rx_state_d = S_START;
      end
      S_START: if (tick_c) begin
        rx_tcnt_d = rx_tcnt_q + 4'd1;
        if (rx_tcnt_q == 4'd7) begin
          rx_tcnt_d  = 4'd0;
          rx_bit_d   = '0;
          rx_state_d = rx_s_c ? S_IDLE : S_DATA;
        end
      end
      S_DATA: if (tick_c) begin
        rx_tcnt_d = rx_tcnt_q + 4'd1;
        if (rx_tcnt_q == 4'd15) begin
          rx_shift_d = {rx_s_c, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == BIT_W'(DATA_BITS - 1)) rx_state_d = S_STOP;
          else rx_bit_d = rx_bit_q + BIT_W'(1);
        end
      end
      S_STOP: if (tick_c) begin
        rx_tcnt_d = rx_tcnt_q + 4'd1;
        if (rx_tcnt_q == 4'd15) begin
          rx_push_c  = 1'b1;
          fe_set_c   = ~rx_s_c;
          rx_state_d = S_IDLE;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      div_q       <= 16'(DIV_RESET);
      tick_cnt_q  <= 16'd0;
      rx_irq_en_q <= 1'b0;
      tx_irq_en_q <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      irq_q       <= 1'b0;
      tx_state_q  <= S_IDLE;
      tx_shift_q  <= '0;
      tx_bit_q    <= '0;
      tx_tcnt_q   <= 4'd0;
      tx_q        <= 1'b1;
      sync_q      <= 2'b11;
      rx_state_q  <= S_IDLE;
      rx_shift_q  <= '0;
      rx_bit_q    <= '0;
      rx_tcnt_q   <= 4'd0;
    end else begin
      div_q       <= div_d;
      tick_cnt_q  <= tick_cnt_d;
      rx_irq_en_q <= rx_irq_en_d;
      tx_irq_en_q <= tx_irq_en_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      irq_q       <= irq_d;
      tx_state_q  <= tx_state_d;
      tx_shift_q  <= tx_shift_d;
      tx_bit_q    <= tx_bit_d;
      tx_tcnt_q   <= tx_tcnt_d;
      tx_q        <= tx_d;
      sync_q      <= sync_d;
      rx_state_q  <= rx_state_d;
      rx_shift_q  <= rx_shift_d;
      rx_bit_q    <= rx_bit_d;
      rx_tcnt_q   <= rx_tcnt_d;
    end
  end
endmodule

// File: tb/tb_apb_uart_fifo.sv
// Scoreboard bench for apb_uart_fifo: APB driver, tx frame monitor and rx frame driver at divisor 4.
`timescale 1ns/1ps

module tb_apb_uart_fifo;
  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic [3:0]  PADDR = 4'd0;
  logic [31:0] PWDATA = 32'd0;
  logic        PWRITE = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR, tx, irq;
  logic        loop_en = 1'b0;
  logic        rx_drv = 1'b1;
  logic        rx_w;
  logic        mon_en = 1'b1;
  logic        last_pready;

  int n_chk = 0;
  int n_pass = 0;
  int tx_frames = 0;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];

  assign rx_w = loop_en ? tx : rx_drv;

  apb_uart_fifo dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .tx(tx), .rx(rx_w), .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge PCLK); PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(negedge PCLK); PENABLE = 1'b1;
    @(negedge PCLK); PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge PCLK); PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(negedge PCLK); PENABLE = 1'b1;
    #1 d = PRDATA; last_pready = PREADY;
    @(negedge PCLK); PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic read_check(input logic [3:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] d;
    apb_read(a, d);
    check(tag, d, exp);
  endtask

  // Pops the rx scoreboard and compares against the RXDATA read
  task automatic read_rx_expect(input string tag);
    logic [31:0] d;
    apb_read(4'h8, d);
    if (rx_exp.size() == 0) check({tag, "_no_expect"}, d, 32'hDEAD_BEEF);
    else check(tag, d, 32'(rx_exp.pop_front()));
  endtask

  task automatic wait_tx_done();
    logic [31:0] s;
    int n = 0;
    bit done = 0;
    while (!done && n < 5000) begin
      apb_read(4'h0, s);
      done = s[0] && !s[6];
      n++;
    end
    if (!done) check("tx_idle_timeout", 32'd0, 32'd1);
    repeat (80) @(negedge PCLK);
  endtask

  task automatic wait_rx_count(input int cnt);
    logic [31:0] s;
    int n = 0;
    bit done = 0;
    while (!done && n < 5000) begin
      apb_read(4'h0, s);
      done = (int'(s[14:11]) >= cnt);
      n++;
    end
    if (!done) check("rx_count_timeout", 32'd0, 32'd1);
  endtask

  // One 64-PCLK-per-bit frame on rx; stop_len shortens the stop bit
  task automatic send_rx(input logic [7:0] b, input logic stopb, input int stop_len);
    rx_drv = 1'b0; repeat (64) @(negedge PCLK);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i]; repeat (64) @(negedge PCLK);
    end
    rx_drv = stopb; repeat (stop_len) @(negedge PCLK);
    rx_drv = 1'b1; repeat (16) @(negedge PCLK);
  endtask

  // tx frame decoder sampling at bit centres
  initial begin : tx_mon
    logic [7:0] b;
    logic       stopb;
    forever begin
      @(negedge tx);
      repeat (32) @(negedge PCLK);
      if (mon_en) check("tx_start_mid", 32'(tx), 32'd0);
      for (int i = 0; i < 8; i++) begin
        repeat (64) @(negedge PCLK);
        b[i] = tx;
      end
      repeat (64) @(negedge PCLK);
      stopb = tx;
      if (mon_en) begin
        if (tx_exp.size() == 0) check("tx_unexpected_frame", 32'(b), 32'hFFFF_FFFF);
        else check("tx_byte", 32'(b), 32'(tx_exp.pop_front()));
        check("tx_stop", 32'(stopb), 32'd1);
        tx_frames++;
      end
    end
  end

  initial begin : main
    logic [31:0] s;
    logic [7:0]  b;

    // Reset state
    repeat (5) @(negedge PCLK);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_irq", 32'(irq), 32'd0);
    PRESET = 1'b0;
    repeat (2) @(negedge PCLK);
    check("prdata_idle", PRDATA, 32'd0);
    read_check(4'h0, 32'h0000_0005, "reset_status");
    check("pready_access", 32'(last_pready), 32'd1);
    read_check(4'hC, 32'h0000_028B, "reset_ctrl");
    read_check(4'h4, 32'h0000_0000, "txdata_reads_0");
    read_check(4'h8, 32'h0000_0000, "rxdata_empty_0");
    check("pslverr", 32'(PSLVERR), 32'd0);

    // Single frame 0xA5
    apb_write(4'hC, 32'd4);
    read_check(4'hC, 32'h0000_0004, "ctrl_div4");
    tx_exp.push_back(8'hA5);
    apb_write(4'h4, 32'h0000_00A5);
    repeat (100) @(negedge PCLK);
    read_check(4'h0, 32'h0000_0045, "status_tx_busy");
    wait_tx_done();

    // Nine back-to-back writes, tenth dropped
    for (int i = 1; i <= 9; i++) begin
      tx_exp.push_back(8'(i));
      apb_write(4'h4, 32'(i));
    end
    read_check(4'h0, 32'h0000_0446, "status_tx_full");
    apb_write(4'h4, 32'h0000_000A);
    read_check(4'h0, 32'h0000_0446, "status_after_drop");
    wait_tx_done();

    // Loopback 0x3C
    loop_en = 1'b1;
    tx_exp.push_back(8'h3C);
    rx_exp.push_back(8'h3C);
    apb_write(4'h4, 32'h0000_003C);
    wait_rx_count(1);
    apb_read(4'h0, s);
    check("loop_rx_count", 32'(s[14:11]), 32'd1);
    read_rx_expect("loop_rxdata");
    wait_tx_done();
    read_check(4'h8, 32'h0000_0000, "loop_rx_empty_read");
    read_check(4'h0, 32'h0000_0005, "loop_status_idle");
    loop_en = 1'b0;
    check("tx_frame_count", 32'(tx_frames), 32'd11);
    check("tx_exp_drained", 32'(tx_exp.size()), 32'd0);

    // Nine rx frames without reading: ninth overruns
    for (int i = 0; i < 9; i++) begin
      b = 8'(i * 29 + 17);
      if (i < 8) rx_exp.push_back(b);
      send_rx(b, 1'b1, 64);
    end
    repeat (20) @(negedge PCLK);
    read_check(4'h0, 32'h0000_4019, "status_rx_overrun");
    check("irq_overrun", 32'(irq), 32'd1);
    for (int i = 0; i < 8; i++) read_rx_expect("rx_fifo_order");
    apb_write(4'h0, 32'h0000_0010);
    read_check(4'h0, 32'h0000_0005, "overrun_w1c");
    repeat (3) @(negedge PCLK);
    check("irq_cleared", 32'(irq), 32'd0);

    // Framing error still pushes the byte
    rx_exp.push_back(8'h55);
    send_rx(8'h55, 1'b0, 40);
    repeat (200) @(negedge PCLK);
    read_rx_expect("fe_rxdata");
    read_check(4'h0, 32'h0000_0025, "status_frame_err");
    check("irq_frame_err", 32'(irq), 32'd1);
    apb_write(4'h0, 32'h0000_0020);
    read_check(4'h0, 32'h0000_0005, "frame_err_w1c");

    // Three-tick glitch is a false start
    rx_drv = 1'b0; repeat (12) @(negedge PCLK);
    rx_drv = 1'b1; repeat (200) @(negedge PCLK);
    read_check(4'h0, 32'h0000_0005, "glitch_no_push");

    // tx_irq_en with idle transmitter
    apb_write(4'hC, 32'h0002_0004);
    repeat (3) @(negedge PCLK);
    check("irq_tx_empty", 32'(irq), 32'd1);
    read_check(4'hC, 32'h0002_0004, "ctrl_irq_en");
    apb_write(4'hC, 32'd4);
    repeat (3) @(negedge PCLK);
    check("irq_tx_en_off", 32'(irq), 32'd0);

    // Reset in the middle of a frame
    mon_en = 1'b0;
    apb_write(4'h4, 32'h0000_0000);
    repeat (200) @(negedge PCLK);
    check("tx_low_mid_frame", 32'(tx), 32'd0);
    PRESET = 1'b1;
    #1 check("tx_async_reset", 32'(tx), 32'd1);
    repeat (3) @(negedge PCLK);
    PRESET = 1'b0;
    read_check(4'h0, 32'h0000_0005, "post_reset_status");
    read_check(4'hC, 32'h0000_028B, "post_reset_ctrl");
    check("post_reset_tx", 32'(tx), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
